// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory request arbiter, plus the check macro that
// mem_req_arbiter uses only when MEM_ARB_ASSERT_EN is defined.
`ifndef MEM_ARB_ASSERT
`define MEM_ARB_ASSERT(cond, msg) assert (cond) else $fatal(1, msg);
`endif

package assert_def;
    localparam bit ASSERT_FATAL = 1'b1;
endpackage

package mem_arb_pkg;
    import assert_def::*;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_NUM_PORTS      = 4;
    localparam int ARB_ADDR_W         = 32;
    localparam int ARB_DATA_W         = 32;
    localparam int ARB_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/mem_arb_rr_pick.sv
// Round-robin picker: first eligible port at or after rr_ptr, wrapping modulo NUM_PORTS.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = ARB_NUM_PORTS,
    localparam int IDX_W = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic                 any_valid,
    output logic [IDX_W-1:0]     pick_idx
);

    logic [2*NUM_PORTS-2:0] dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [IDX_W-1:0]       offset;
    logic [IDX_W:0]         sum;

    // Doubling the vector lets a single part-select rotate rr_ptr to bit 0.
    assign dbl = {eligible[NUM_PORTS-2:0], eligible};
    assign rot = dbl[rr_ptr +: NUM_PORTS];

    always_comb begin
        offset = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = IDX_W'(k);
            end
        end
    end

    always_comb begin
        any_valid = |eligible;
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(NUM_PORTS)) begin
            sum = sum - (IDX_W + 1)'(NUM_PORTS);
        end
        pick_idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_PORTS requesters.
// Optional simulation checks are compiled in when MEM_ARB_ASSERT_EN is defined.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS      = ARB_NUM_PORTS,
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int DATA_W         = ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wr_data,
    output logic [NUM_PORTS-1:0]        req_ack,
    output logic [DATA_W-1:0]           rsp_rd_data,
    output logic                        mem_req,
    output logic                        mem_wr,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wr_data,
    input  logic                        mem_ack,
    input  logic [DATA_W-1:0]           mem_rd_data,
    output logic                        busy,
    output logic                        timeout_err
);

    // state    | meaning
    // ARB_IDLE | no transaction; arbitrate among eligible ports each cycle
    // ARB_BUSY | grantee's request latched on the memory port, waiting for mem_ack

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     pick_idx;
    logic                 any_valid;
    logic [NUM_PORTS-1:0] eligible;
    logic [CNT_W-1:0]     tmo_cnt;
    logic                 grant;
    logic                 complete;

    // The port acked this cycle still shows its old valid; keep it out of the race.
    assign eligible = req_valid & ~req_ack;

    mem_arb_rr_pick #(
        .NUM_PORTS(NUM_PORTS)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .any_valid(any_valid),
        .pick_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (any_valid) state_nxt = ARB_BUSY;
            ARB_BUSY: if (mem_ack)   state_nxt = ARB_IDLE;
            default:                 state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state == ARB_BUSY);
        busy     = (state == ARB_BUSY);
        grant    = (state == ARB_IDLE) && any_valid;
        complete = (state == ARB_BUSY) && mem_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            req_ack     <= '0;
            rsp_rd_data <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            req_ack <= '0;
            if (grant) begin
                gnt_idx     <= pick_idx;
                mem_wr      <= req_wr[pick_idx];
                mem_addr    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                mem_wr_data <= req_wr_data[pick_idx*DATA_W +: DATA_W];
                tmo_cnt     <= '0;
            end
            if (state == ARB_BUSY) begin
                if (int'(tmo_cnt) < TIMEOUT_CYCLES) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                if (TIMEOUT_CYCLES != 0 && int'(tmo_cnt) == TIMEOUT_CYCLES - 1) begin
                    timeout_err <= 1'b1;
                end
            end
            if (complete) begin
                req_ack     <= NUM_PORTS'(1) << gnt_idx;
                rsp_rd_data <= mem_rd_data;
                rr_ptr      <= (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

`ifdef MEM_ARB_ASSERT_EN
    logic [NUM_PORTS-1:0] prev_valid;
    logic [NUM_PORTS-1:0] prev_ack;
    logic                 prev_busy;
    logic                 prev_wr;
    logic [ADDR_W-1:0]    prev_addr;
    logic [DATA_W-1:0]    prev_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid <= '0;
            prev_ack   <= '0;
            prev_busy  <= 1'b0;
            prev_wr    <= 1'b0;
            prev_addr  <= '0;
            prev_wdata <= '0;
        end else begin
            prev_valid <= req_valid;
            prev_ack   <= req_ack;
            prev_busy  <= busy;
            prev_wr    <= mem_wr;
            prev_addr  <= mem_addr;
            prev_wdata <= mem_wr_data;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            `MEM_ARB_ASSERT(!$isunknown(req_valid) && !$isunknown(mem_ack), "mem_req_arbiter: unknown req_valid or mem_ack")
            `MEM_ARB_ASSERT(state != ARB_BUSY || !$isunknown(mem_rd_data), "mem_req_arbiter: unknown mem_rd_data while busy")
            `MEM_ARB_ASSERT($onehot0(req_ack), "mem_req_arbiter: req_ack not one-hot")
            `MEM_ARB_ASSERT(!(state == ARB_IDLE && mem_ack), "mem_req_arbiter: mem_ack while idle")
            `MEM_ARB_ASSERT((prev_valid & ~req_valid & ~(prev_ack | req_ack)) == '0, "mem_req_arbiter: req_valid dropped before req_ack")
            `MEM_ARB_ASSERT(!(prev_busy && busy) || (mem_wr == prev_wr && mem_addr == prev_addr && mem_wr_data == prev_wdata), "mem_req_arbiter: latched request changed while busy")
        end
    end
`endif

endmodule
